// File: rtl/podule_cycle_ctl.sv
// podule_cycle_ctl
//   Bus-side responder for the podule. It takes the region selects from the
//   address decoder and turns them into complete device cycles. The
//   asynchronous podule strobes pass through 2-FF synchronisers. A per-region
//   wait-state sequencer drives the shared device strobes. Read data is
//   returned with a ready handshake. The on-card registers live here too:
//   the flash page latch, the IDE high-byte latch, and the interrupt view.
//
// Ports
//   clk, rst_n              system clock, async active-low reset
//   ps_n, ior_n, iow_n      podule select/read/write strobes (asynchronous)
//   a[2:0]                  address bits [4:2], device register select
//   *_cs                    region selects from the podule address decoder
//   bus_din / bus_dout      podule write data / read data
//   bus_oe, podule_rdy      read-data drive enable, cycle complete
//   dev_sel[4:0]            one-hot {eth,uart,ide,econet,rom}
//   dev_a, dev_rd_n/wr_n    registered register select and device strobes
//   dev_din / dev_dout      16-bit device read / write data
//   irq_in                  interrupt sources (read through interrupt_cs)
//   rom_page                flash page latch

// 2-FF synchroniser for an active-low strobe; it resets to the idle level.
module podule_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module podule_cycle_ctl #(
  parameter int ROM_WAIT    = 3,
  parameter int ECONET_WAIT = 4,
  parameter int IDE_WAIT    = 5,
  parameter int UART_WAIT   = 3,
  parameter int ETH_WAIT    = 4,
  parameter int WAIT_W      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps_n,
  input  logic        ior_n,
  input  logic        iow_n,
  input  logic [2:0]  a,
  input  logic        rom_cs,
  input  logic        econet_cs,
  input  logic        ide_cs,
  input  logic        ide2_cs,
  input  logic        interrupt_cs,
  input  logic        fpl_cs,
  input  logic        uart_cs,
  input  logic        ethernet_cs,
  input  logic [7:0]  bus_din,
  output logic [7:0]  bus_dout,
  output logic        bus_oe,
  output logic        podule_rdy,
  output logic [4:0]  dev_sel,
  output logic [2:0]  dev_a,
  output logic        dev_rd_n,
  output logic        dev_wr_n,
  input  logic [15:0] dev_din,
  output logic [15:0] dev_dout,
  input  logic [7:0]  irq_in,
  output logic [7:0]  rom_page
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;
  typedef enum logic [3:0] {
    R_NONE, R_ROM, R_ECO, R_IDE, R_UART, R_ETH, R_IRQ, R_FPL, R_IDE2
  } region_t;

  typedef struct packed {
    region_t     region;
    logic [2:0]  a;
    logic        is_rd;
    logic [7:0]  din;
  } req_t;

  // ---- strobe synchronisers: bit0 ps_n, bit1 ior_n, bit2 iow_n
  localparam int NSYNC = 3;
  logic [NSYNC-1:0] strb_raw, strb_s;
  assign strb_raw = {iow_n, ior_n, ps_n};

  genvar gi;
  generate
    for (gi = 0; gi < NSYNC; gi++) begin : g_sync
      podule_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(strb_raw[gi]), .q(strb_s[gi]));
    end
  endgenerate

  logic rd, wr;
  assign rd = ~strb_s[0] & ~strb_s[1];
  assign wr = ~strb_s[0] & ~strb_s[2];

  // ---- region decode (the decoder gives one-hot selects; the priority only
  //      resolves a broken decode deterministically)
  region_t region_dec;
  always_comb begin
    region_dec = R_NONE;
    if      (rom_cs)       region_dec = R_ROM;
    else if (econet_cs)    region_dec = R_ECO;
    else if (ide_cs)       region_dec = R_IDE;
    else if (uart_cs)      region_dec = R_UART;
    else if (ethernet_cs)  region_dec = R_ETH;
    else if (interrupt_cs) region_dec = R_IRQ;
    else if (fpl_cs)       region_dec = R_FPL;
    else if (ide2_cs)      region_dec = R_IDE2;
  end

  function automatic logic is_dev(input region_t r);
    return (r == R_ROM) || (r == R_ECO) || (r == R_IDE) ||
           (r == R_UART) || (r == R_ETH);
  endfunction

  function automatic logic [WAIT_W-1:0] wait_of(input region_t r);
    logic [WAIT_W-1:0] w;
    case (r)
      R_ROM:   w = WAIT_W'(ROM_WAIT);
      R_ECO:   w = WAIT_W'(ECONET_WAIT);
      R_IDE:   w = WAIT_W'(IDE_WAIT);
      R_UART:  w = WAIT_W'(UART_WAIT);
      R_ETH:   w = WAIT_W'(ETH_WAIT);
      default: w = '0;
    endcase
    return w;
  endfunction

  function automatic logic [4:0] sel_of(input region_t r);
    logic [4:0] s;
    case (r)
      R_ROM:   s = 5'b00001;
      R_ECO:   s = 5'b00010;
      R_IDE:   s = 5'b00100;
      R_UART:  s = 5'b01000;
      R_ETH:   s = 5'b10000;
      default: s = 5'b00000;
    endcase
    return s;
  endfunction

  // ---- state and registered outputs
  state_t            state_q, state_d;
  req_t              req_q, req_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        bus_dout_d, rom_page_d;
  logic              bus_oe_d, rdy_d, dev_rd_n_d, dev_wr_n_d;
  logic [4:0]        dev_sel_d;
  logic [2:0]        dev_a_d;
  logic [15:0]       dev_dout_d;
  logic              finish;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    bus_dout_d = bus_dout;
    bus_oe_d   = bus_oe;
    rdy_d      = podule_rdy;
    dev_sel_d  = dev_sel;
    dev_a_d    = dev_a;
    dev_rd_n_d = dev_rd_n;
    dev_wr_n_d = dev_wr_n;
    dev_dout_d = dev_dout;
    rom_page_d = rom_page;
    finish     = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Direction is fixed at acceptance so a strobe that drops during
        // SETUP cannot turn the cycle into a write. Read wins over write.
        if (rd || wr) begin
          state_d     = S_SETUP;
          req_d.is_rd = rd;
        end
      end

      S_SETUP: begin
        req_d.region = region_dec;
        req_d.a      = a;
        req_d.din    = bus_din;
        dev_a_d      = a;
        dev_sel_d    = sel_of(region_dec);
        cnt_d        = wait_of(region_dec);
        if (!req_q.is_rd)
          dev_dout_d = (region_dec == R_IDE && a == 3'd0) ? {hi_q, bus_din}
                                                           : {8'h00, bus_din};
        if (is_dev(region_dec)) begin
          dev_rd_n_d = ~req_q.is_rd;
          dev_wr_n_d =  req_q.is_rd;
        end
        state_d = S_STROBE;
      end

      S_STROBE: begin
        if (is_dev(req_q.region)) begin
          if (cnt_q == '0) begin
            if (req_q.is_rd) begin
              bus_dout_d = dev_din[7:0];
              // The IDE data register is 16 bits wide. Its high byte is parked
              // here for a later ide2_cs read.
              if (req_q.region == R_IDE && req_q.a == 3'd0)
                hi_d = dev_din[15:8];
            end
            dev_rd_n_d = 1'b1;
            dev_wr_n_d = 1'b1;
            dev_sel_d  = '0;
            finish     = 1'b1;
          end else begin
            cnt_d = cnt_q - WAIT_W'(1);
          end
        end else begin
          case (req_q.region)
            R_IRQ:  if (req_q.is_rd) bus_dout_d = irq_in;
            R_FPL:  if (req_q.is_rd) bus_dout_d = rom_page;
                    else             rom_page_d = req_q.din;
            R_IDE2: if (req_q.is_rd) bus_dout_d = hi_q;
                    else             hi_d       = req_q.din;
            default: if (req_q.is_rd) bus_dout_d = 8'hFF;  // null cycle
          endcase
          finish = 1'b1;
        end
        if (finish) begin
          state_d  = S_DONE;
          rdy_d    = 1'b1;
          bus_oe_d = req_q.is_rd;
        end
      end

      S_DONE: begin
        if (!rd && !wr) begin
          state_d  = S_IDLE;
          rdy_d    = 1'b0;
          bus_oe_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= 8'h00;
      bus_dout   <= 8'h00;
      bus_oe     <= 1'b0;
      podule_rdy <= 1'b0;
      dev_sel    <= '0;
      dev_a      <= '0;
      dev_rd_n   <= 1'b1;
      dev_wr_n   <= 1'b1;
      dev_dout   <= '0;
      rom_page   <= 8'h00;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      bus_dout   <= bus_dout_d;
      bus_oe     <= bus_oe_d;
      podule_rdy <= rdy_d;
      dev_sel    <= dev_sel_d;
      dev_a      <= dev_a_d;
      dev_rd_n   <= dev_rd_n_d;
      dev_wr_n   <= dev_wr_n_d;
      dev_dout   <= dev_dout_d;
      rom_page   <= rom_page_d;
    end
  end

endmodule

// File: tb/tb_podule_cycle_ctl.sv
module tb_podule_cycle_ctl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ps_n, ior_n, iow_n;
  logic [2:0]  a;
  logic        rom_cs, econet_cs, ide_cs, ide2_cs, interrupt_cs, fpl_cs, uart_cs, ethernet_cs;
  logic [7:0]  bus_din, bus_dout;
  logic        bus_oe, podule_rdy;
  logic [4:0]  dev_sel;
  logic [2:0]  dev_a;
  logic        dev_rd_n, dev_wr_n;
  logic [15:0] dev_din, dev_dout;
  logic [7:0]  irq_in, rom_page;

  always #5 clk = ~clk;

  podule_cycle_ctl dut (
    .clk(clk), .rst_n(rst_n), .ps_n(ps_n), .ior_n(ior_n), .iow_n(iow_n), .a(a),
    .rom_cs(rom_cs), .econet_cs(econet_cs), .ide_cs(ide_cs), .ide2_cs(ide2_cs),
    .interrupt_cs(interrupt_cs), .fpl_cs(fpl_cs), .uart_cs(uart_cs),
    .ethernet_cs(ethernet_cs), .bus_din(bus_din), .bus_dout(bus_dout),
    .bus_oe(bus_oe), .podule_rdy(podule_rdy), .dev_sel(dev_sel), .dev_a(dev_a),
    .dev_rd_n(dev_rd_n), .dev_wr_n(dev_wr_n), .dev_din(dev_din),
    .dev_dout(dev_dout), .irq_in(irq_in), .rom_page(rom_page)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // cs bit order: {eth, uart, fpl, irq, ide2, ide, econet, rom}
  task automatic set_cs(input logic [7:0] cs);
    {ethernet_cs, uart_cs, fpl_cs, interrupt_cs, ide2_cs, ide_cs, econet_cs, rom_cs} = cs;
  endtask

  // Watch a cycle from strobe assertion until podule_rdy (bounded).
  task automatic watch(output int lat, output int rdc, output int wrc,
                       output logic [4:0] sel, output logic [15:0] dd, output logic oe);
    lat = 99; rdc = 0; wrc = 0; sel = '0; dd = '0; oe = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!dev_rd_n) begin rdc++; sel = dev_sel; end
      if (!dev_wr_n) begin wrc++; sel = dev_sel; dd = dev_dout; end
      if (podule_rdy) begin lat = n; oe = bus_oe; break; end
    end
  endtask

  task automatic release_bus(output int rl, output logic oe2);
    ps_n = 1'b1; ior_n = 1'b1; iow_n = 1'b1;
    rl = 99; oe2 = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (!podule_rdy) begin rl = n; oe2 = bus_oe; break; end
    end
  endtask

  task automatic run_txn(input string nm, input logic [7:0] cs, input logic r, input logic w,
                         input logic [2:0] aa, input logic [7:0] din, input logic [15:0] ddin,
                         input logic [7:0] irq, input logic [7:0] e_dout, input logic [7:0] e_page,
                         input int e_lat, input int e_rdc, input int e_wrc,
                         input logic [4:0] e_sel, input logic [15:0] e_dd);
    int lat, rdc, wrc, rl;
    logic [4:0] sel;
    logic [15:0] dd;
    logic oe, oe2;
    @(posedge clk); #1;
    set_cs(cs);
    a = aa; bus_din = din; dev_din = ddin; irq_in = irq;
    ps_n = 1'b0; ior_n = !r; iow_n = !w;
    watch(lat, rdc, wrc, sel, dd, oe);
    chk({nm, " latency"}, lat, e_lat);
    chk({nm, " rd_strobe_cycles"}, rdc, e_rdc);
    chk({nm, " wr_strobe_cycles"}, wrc, e_wrc);
    chk({nm, " dev_sel"}, {27'd0, sel}, {27'd0, e_sel});
    chk({nm, " dev_dout"}, {16'd0, dd}, {16'd0, e_dd});
    if (r) chk({nm, " bus_dout"}, {24'd0, bus_dout}, {24'd0, e_dout});
    chk({nm, " bus_oe"}, {31'd0, oe}, {31'd0, r});
    chk({nm, " rom_page"}, {24'd0, rom_page}, {24'd0, e_page});
    chk({nm, " dev_a"}, {29'd0, dev_a}, {29'd0, aa});
    release_bus(rl, oe2);
    chk({nm, " rdy_release"}, rl, 3);
    chk({nm, " oe_release"}, {31'd0, oe2}, 32'd0);
  endtask

  typedef struct {
    logic [7:0]  cs;
    logic        r, w;
    logic [2:0]  a;
    logic [7:0]  din;
    logic [15:0] ddin;
    logic [7:0]  irq;
    logic [7:0]  e_dout, e_page;
    int          e_lat, e_rdc, e_wrc;
    logic [4:0]  e_sel;
    logic [15:0] e_dd;
  } vec_t;

  vec_t tbl[13];

  // Reference model: device regions strobe for WAIT+1 cycles; -1 = internal.
  function automatic int ref_wait(input int k);
    case (k)
      1: return 3;  2: return 4;  3: return 5;  7: return 3;  8: return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [4:0] ref_sel(input int k);
    case (k)
      1: return 5'b00001;  2: return 5'b00010;  3: return 5'b00100;
      7: return 5'b01000;  8: return 5'b10000;
      default: return 5'b00000;
    endcase
  endfunction

  logic [7:0]  page_m, hi_m;
  int          k, dir, wt, e_lat, e_rdc, e_wrc;
  logic        r, w;
  logic [2:0]  aa;
  logic [7:0]  din, irq, e_dout;
  logic [15:0] ddin, e_dd;
  logic [4:0]  e_sel;
  int          lat, rdc, wrc, rl, first, hi_cnt;
  logic [4:0]  sel;
  logic [15:0] dd;
  logic        oe, oe2;

  initial begin
    // ---- reset held with a read strobe pending
    rst_n = 1'b0; ps_n = 1'b0; ior_n = 1'b0; iow_n = 1'b1; a = '0;
    set_cs(8'h01); bus_din = '0; dev_din = 16'h12A5; irq_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst bus_dout", {24'd0, bus_dout}, 0);
    chk("rst bus_oe", {31'd0, bus_oe}, 0);
    chk("rst podule_rdy", {31'd0, podule_rdy}, 0);
    chk("rst dev_sel", {27'd0, dev_sel}, 0);
    chk("rst dev_a", {29'd0, dev_a}, 0);
    chk("rst dev_rd_n", {31'd0, dev_rd_n}, 1);
    chk("rst dev_wr_n", {31'd0, dev_wr_n}, 1);
    chk("rst dev_dout", {16'd0, dev_dout}, 0);
    chk("rst rom_page", {24'd0, rom_page}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    watch(lat, rdc, wrc, sel, dd, oe);
    chk("post_rst latency", lat, 8);
    chk("post_rst rd_strobe_cycles", rdc, 4);
    chk("post_rst bus_dout", {24'd0, bus_dout}, 32'hA5);
    release_bus(rl, oe2);
    chk("post_rst rdy_release", rl, 3);

    // ---- table-driven vectors
    tbl[0]  = '{8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 16'h12A5, 8'h00, 8'hA5, 8'h00,  8, 4, 0, 5'b00001, 16'h0000};
    tbl[1]  = '{8'h08, 1'b0, 1'b1, 3'd0, 8'hBE, 16'h0000, 8'h00, 8'h00, 8'h00,  5, 0, 0, 5'b00000, 16'h0000};
    tbl[2]  = '{8'h04, 1'b0, 1'b1, 3'd0, 8'hEF, 16'h0000, 8'h00, 8'h00, 8'h00, 10, 0, 6, 5'b00100, 16'hBEEF};
    tbl[3]  = '{8'h04, 1'b1, 1'b0, 3'd0, 8'h00, 16'hCAFE, 8'h00, 8'hFE, 8'h00, 10, 6, 0, 5'b00100, 16'h0000};
    tbl[4]  = '{8'h08, 1'b1, 1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, 8'hCA, 8'h00,  5, 0, 0, 5'b00000, 16'h0000};
    tbl[5]  = '{8'h20, 1'b0, 1'b1, 3'd0, 8'h3C, 16'h0000, 8'h00, 8'h00, 8'h3C,  5, 0, 0, 5'b00000, 16'h0000};
    tbl[6]  = '{8'h10, 1'b1, 1'b0, 3'd0, 8'h00, 16'h0000, 8'h81, 8'h81, 8'h3C,  5, 0, 0, 5'b00000, 16'h0000};
    tbl[7]  = '{8'h00, 1'b1, 1'b0, 3'd0, 8'h00, 16'h0000, 8'h00, 8'hFF, 8'h3C,  5, 0, 0, 5'b00000, 16'h0000};
    tbl[8]  = '{8'h02, 1'b1, 1'b1, 3'd5, 8'h00, 16'h5A5A, 8'h00, 8'h5A, 8'h3C,  9, 5, 0, 5'b00010, 16'h0000};
    tbl[9]  = '{8'h40, 1'b0, 1'b1, 3'd3, 8'h77, 16'h0000, 8'h00, 8'h00, 8'h3C,  8, 0, 4, 5'b01000, 16'h0077};
    tbl[10] = '{8'h80, 1'b1, 1'b0, 3'd6, 8'h00, 16'h9911, 8'h00, 8'h11, 8'h3C,  9, 5, 0, 5'b10000, 16'h0000};
    tbl[11] = '{8'h10, 1'b0, 1'b1, 3'd0, 8'h55, 16'h0000, 8'h81, 8'h00, 8'h3C,  5, 0, 0, 5'b00000, 16'h0000};
    tbl[12] = '{8'h04, 1'b0, 1'b1, 3'd1, 8'h42, 16'h0000, 8'h00, 8'h00, 8'h3C, 10, 0, 6, 5'b00100, 16'h0042};
    for (int i = 0; i < 13; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].cs, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].din,
              tbl[i].ddin, tbl[i].irq, tbl[i].e_dout, tbl[i].e_page, tbl[i].e_lat,
              tbl[i].e_rdc, tbl[i].e_wrc, tbl[i].e_sel, tbl[i].e_dd);
    page_m = 8'h3C;
    hi_m   = 8'hCA;

    // ---- strobes dropped during SETUP: cycle completes, rdy pulses once
    @(posedge clk); #1;
    set_cs(8'h01); a = 3'd0; dev_din = 16'h00C3; ps_n = 1'b0; ior_n = 1'b0; iow_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    ps_n = 1'b1; ior_n = 1'b1;
    first = 99; hi_cnt = 0; rdc = 0;
    for (int n = 4; n <= 30; n++) begin
      @(posedge clk); #1;
      if (!dev_rd_n) rdc++;
      if (podule_rdy) begin
        hi_cnt++;
        if (first == 99) first = n;
      end
    end
    chk("early_drop rdy_at", first, 8);
    chk("early_drop rdy_cycles", hi_cnt, 1);
    chk("early_drop rd_strobe_cycles", rdc, 4);
    chk("early_drop bus_dout", {24'd0, bus_dout}, 32'hC3);
    chk("early_drop bus_oe", {31'd0, bus_oe}, 0);

    // ---- randomized transactions against the reference model
    for (int t = 0; t < 40; t++) begin
      k   = $urandom_range(0, 8);
      dir = $urandom_range(0, 2);           // 0 read, 1 write, 2 both
      r   = (dir != 1);
      w   = (dir != 0);
      aa  = ($urandom_range(0, 1) == 1) ? 3'd0 : 3'($urandom_range(0, 7));
      din = 8'($urandom);  ddin = 16'($urandom);  irq = 8'($urandom);
      e_dout = '0; e_dd = '0; e_rdc = 0; e_wrc = 0;
      e_sel = ref_sel(k);
      wt = ref_wait(k);
      if (wt >= 0) begin
        e_lat = wt + 5;
        if (r) begin
          e_rdc  = wt + 1;
          e_dout = ddin[7:0];
          if (k == 3 && aa == 3'd0) hi_m = ddin[15:8];
        end else begin
          e_wrc = wt + 1;
          e_dd  = (k == 3 && aa == 3'd0) ? {hi_m, din} : {8'h00, din};
        end
      end else begin
        e_lat = 5;
        case (k)
          4: if (r) e_dout = hi_m;   else hi_m   = din;
          5: if (r) e_dout = irq;
          6: if (r) e_dout = page_m; else page_m = din;
          default: if (r) e_dout = 8'hFF;
        endcase
      end
      run_txn($sformatf("rnd%0d", t), (k == 0) ? 8'h00 : 8'(1 << (k - 1)), r, w, aa, din,
              ddin, irq, e_dout, page_m, e_lat, e_rdc, e_wrc, e_sel, e_dd);
    end

    // ---- reset during the strobe phase of an econet read
    @(posedge clk); #1;
    set_cs(8'h02); ps_n = 1'b0; ior_n = 1'b0; iow_n = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("mid_rst strobe_active", {31'd0, dev_rd_n}, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst dev_rd_n", {31'd0, dev_rd_n}, 1);
    chk("mid_rst podule_rdy", {31'd0, podule_rdy}, 0);
    chk("mid_rst dev_sel", {27'd0, dev_sel}, 0);
    chk("mid_rst rom_page", {24'd0, rom_page}, 0);
    ps_n = 1'b1; ior_n = 1'b1; set_cs(8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    chk("after_rst idle_rdy", {31'd0, podule_rdy}, 0);
    chk("after_rst idle_rd_n", {31'd0, dev_rd_n}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
